uart_alu_frame_ctrl: RTL and testbench

//  Downstream consumer of the UART receiver. Assembles three received bytes (operand A,

---
 rtl/uart_alu_frame_ctrl_pkg.sv | 30 +++
 rtl/uart_alu_frame_ctrl_timer.sv | 31 +++
 rtl/uart_alu_frame_ctrl.sv | 108 ++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_frame_ctrl_pkg.sv
// Shared definitions for the UART ALU frame controller: FSM states, default widths
// and the opcode values understood by the external ALU.
package uart_alu_frame_ctrl_pkg;

  localparam int NB_BIT_DEF = 8;
  localparam int NB_OP_DEF  = 6;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  // True while a partial frame is being collected and the gap timer must run.
  function automatic logic in_frame(input state_t s);
    return (s == ST_GET_B) || (s == ST_GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_frame_ctrl_timer.sv
// Idle-gap timer between bytes of one frame; expire is combinational on the last
// allowed cycle so the controller can give a same-cycle byte priority over it.
module frame_gap_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] MAX_CNT  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST_CNT = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [TW-1:0] count_q;

  assign expire = (TIMEOUT_CYCLES > 0) && enable && (count_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear || !enable || expire) begin
      count_q <= '0;
    end else if (count_q != MAX_CNT) begin
      count_q <= count_q + TW'(1);
    end
  end

endmodule

// File: rtl/uart_alu_frame_ctrl.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, drives an
// external ALU and hands the result byte to the UART transmitter.
module uart_alu_frame_ctrl
  import uart_alu_frame_ctrl_pkg::*;
#(
  parameter int NB_BIT         = NB_BIT_DEF,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done_tick,
  input  logic [NB_BIT-1:0] rx_data,
  input  logic [NB_BIT-1:0] alu_result,
  input  logic              tx_done_tick,
  output logic [NB_BIT-1:0] alu_a,
  output logic [NB_BIT-1:0] alu_b,
  output logic [NB_OP-1:0]  alu_op,
  output logic              tx_start,
  output logic [NB_BIT-1:0] tx_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [2:0]        state_dbg
);

  // Handshakes: rx_done_tick is a valid-only strobe with no back-pressure, so a byte
  // arriving outside GET_A/GET_B/GET_OP is simply dropped. tx_start is a one-cycle
  // request; the transmitter answers with a one-cycle tx_done_tick when the byte is out.

  state_t state_q, state_d;
  logic   accept;
  logic   time_out;
  logic   expire;

  frame_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept | time_out),
    .enable (in_frame(state_q)),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_GET_A;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    time_out = 1'b0;
    case (state_q)
      ST_GET_A: begin
        if (rx_done_tick) begin
          accept  = 1'b1;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (rx_done_tick) begin
          accept  = 1'b1;
          state_d = ST_GET_OP;
        end else if (expire) begin
          time_out = 1'b1;
          state_d  = ST_GET_A;
        end
      end
      ST_GET_OP: begin
        if (rx_done_tick) begin
          accept  = 1'b1;
          state_d = ST_SEND;
        end else if (expire) begin
          time_out = 1'b1;
          state_d  = ST_GET_A;
        end
      end
      ST_SEND:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done_tick) state_d = ST_GET_A;
      default:    state_d = ST_GET_A;
    endcase
  end

  // Operands are only overwritten by an accepted byte of their own field, so they
  // stay stable for the ALU from SEND until the next frame reaches that field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_start    <= (state_q == ST_SEND);
      timeout_err <= time_out;
      if (accept && state_q == ST_GET_A)  alu_a  <= rx_data;
      if (accept && state_q == ST_GET_B)  alu_b  <= rx_data;
      if (accept && state_q == ST_GET_OP) alu_op <= rx_data[NB_OP-1:0];
      if (state_q == ST_SEND)             tx_data <= alu_result;
    end
  end

  assign busy      = (state_q == ST_SEND) || (state_q == ST_WAIT_TX);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Directed bench for uart_alu_frame_ctrl with a behavioural ALU in the loop.
module tb_uart_alu_frame_ctrl;
  import uart_alu_frame_ctrl_pkg::*;

  logic       clk;
  logic       reset;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic [7:0] alu_result;
  logic       tx_done_tick;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       timeout_err;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int to_cnt    = 0;
  int snap_start;
  int snap_to;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_alu_frame_ctrl #(
    .NB_BIT(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .alu_result   (alu_result),
    .tx_done_tick (tx_done_tick),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // External ALU model
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_result = alu_a + alu_b;
      OP_SUB:  alu_result = alu_a - alu_b;
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_XOR:  alu_result = alu_a ^ alu_b;
      OP_NOR:  alu_result = ~(alu_a | alu_b);
      OP_SRA:  alu_result = $signed(alu_a) >>> alu_b;
      OP_SRL:  alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (tx_start === 1'b1)    start_cnt++;
    if (timeout_err === 1'b1) to_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
  endtask

  task automatic tx_done();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
  endtask

  // Three bytes, then two cycles so the tx_start pulse has already happened.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    tick();
    tick();
  endtask

  initial begin
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    repeat (2) tick();

    // reset state
    check("rst_state", 16'(state_dbg), 16'd0);
    check("rst_alu_a", 16'(alu_a), 16'h0);
    check("rst_tx_start", 16'(tx_start), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_timeout_err", 16'(timeout_err), 16'd0);
    reset = 1'b1;
    tick();

    // 1: ADD frame, latency and busy
    snap_start = start_cnt;
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    check("add_send_state", 16'(state_dbg), 16'd3);
    check("add_send_busy", 16'(busy), 16'd1);
    check("add_no_start_early", 16'(tx_start), 16'd0);
    tick();
    check("add_tx_start", 16'(tx_start), 16'd1);
    check("add_tx_data", 16'(tx_data), 16'h08);
    check("add_alu_a", 16'(alu_a), 16'h05);
    check("add_alu_b", 16'(alu_b), 16'h03);
    check("add_alu_op", 16'(alu_op), 16'h20);
    tick();
    check("add_start_one_cycle", 16'(tx_start), 16'd0);
    check("add_busy_wait", 16'(busy), 16'd1);
    tx_done();
    check("add_idle_busy", 16'(busy), 16'd0);
    check("add_idle_state", 16'(state_dbg), 16'd0);
    check("add_start_pulses", 16'(start_cnt - snap_start), 16'd1);

    // 2: back-to-back SUB then OR
    snap_start = start_cnt;
    run_frame(8'h0A, 8'h0C, 8'h22);
    check("sub_tx_data", 16'(tx_data), 16'hFE);
    tx_done();
    run_frame(8'hF0, 8'h0F, 8'h25);
    check("or_tx_data", 16'(tx_data), 16'hFF);
    tx_done();
    check("b2b_start_pulses", 16'(start_cnt - snap_start), 16'd2);

    // 3: timeout after one byte, 100 idle cycles
    snap_to = to_cnt;
    send_byte(8'h11);
    repeat (99) tick();
    check("to_not_yet_state", 16'(state_dbg), 16'd1);
    check("to_not_yet_err", 16'(timeout_err), 16'd0);
    tick();
    check("to_state", 16'(state_dbg), 16'd0);
    check("to_err_pulse", 16'(timeout_err), 16'd1);
    tick();
    check("to_err_one_cycle", 16'(timeout_err), 16'd0);
    check("to_err_count", 16'(to_cnt - snap_to), 16'd1);
    run_frame(8'h01, 8'h02, 8'h20);
    check("to_next_tx_data", 16'(tx_data), 16'h03);
    check("to_next_alu_a", 16'(alu_a), 16'h01);
    tx_done();

    // 4: bytes during a long WAIT_TX are dropped, no timeout there
    snap_start = start_cnt;
    snap_to    = to_cnt;
    run_frame(8'h10, 8'h20, 8'h20);
    check("wt_tx_data", 16'(tx_data), 16'h30);
    send_byte(8'h55);
    repeat (3) tick();
    send_byte(8'h66);
    repeat (150) tick();
    check("wt_state", 16'(state_dbg), 16'd4);
    check("wt_alu_a_kept", 16'(alu_a), 16'h10);
    check("wt_alu_b_kept", 16'(alu_b), 16'h20);
    check("wt_no_timeout", 16'(to_cnt - snap_to), 16'd0);
    tx_done();
    run_frame(8'h09, 8'h04, 8'h22);
    check("wt_next_alu_a", 16'(alu_a), 16'h09);
    check("wt_next_tx_data", 16'(tx_data), 16'h05);
    tx_done();
    check("wt_start_pulses", 16'(start_cnt - snap_start), 16'd2);

    // 5a: byte on the exact expiry cycle wins
    snap_to = to_cnt;
    send_byte(8'h10);
    repeat (99) tick();
    send_byte(8'h20);
    check("exp_byte_state", 16'(state_dbg), 16'd2);
    check("exp_byte_alu_b", 16'(alu_b), 16'h20);
    check("exp_byte_no_err", 16'(timeout_err), 16'd0);
    send_byte(8'h24);
    tick();
    tick();
    check("exp_and_tx_data", 16'(tx_data), 16'h00);
    check("exp_no_timeout", 16'(to_cnt - snap_to), 16'd0);

    // 5b: rx_done_tick together with tx_done_tick
    rx_data      = 8'h77;
    rx_done_tick = 1'b1;
    tx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    check("both_state", 16'(state_dbg), 16'd0);
    check("both_alu_a_kept", 16'(alu_a), 16'h10);
    run_frame(8'h30, 8'h03, 8'h02);
    check("both_next_alu_a", 16'(alu_a), 16'h30);
    check("both_next_srl", 16'(tx_data), 16'h06);
    tx_done();

    // 6: asynchronous reset after byte B
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", 16'(state_dbg), 16'd0);
    check("arst_alu_a", 16'(alu_a), 16'h00);
    check("arst_alu_b", 16'(alu_b), 16'h00);
    check("arst_alu_op", 16'(alu_op), 16'h00);
    check("arst_tx_data", 16'(tx_data), 16'h00);
    @(negedge clk);
    reset = 1'b1;
    tick();
    snap_start = start_cnt;
    send_byte(8'h07);
    send_byte(8'h01);
    check("arst_b_stored", 16'(alu_b), 16'h01);
    check("arst_no_early_start", 16'(start_cnt - snap_start), 16'd0);
    send_byte(8'h03);
    tick();
    check("arst_sra_start", 16'(tx_start), 16'd1);
    check("arst_sra_tx_data", 16'(tx_data), 16'h03);
    tick();
    tx_done();
    check("arst_start_pulses", 16'(start_cnt - snap_start), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
